ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the PS2_CLK/PS2_DAT open-drain pair.
- It is the sending end of the link the existing PS/2 receive path listens on.
- The top level wires its outputs to tri-state drivers on PS2_CLK/PS2_DAT. `busy` gates `received_data_en` so the receive path ignores traffic during a transmit.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 36 +++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host-to-device transmit path.
//   state_e      : transmitter FSM states
//   CMD_*        : common keyboard command bytes
//   FRAME_BITS   : bits the host drives after the start bit (8 data, parity, stop)
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE,
        DONE,
        ERROR
    } state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Multi-flop synchroniser for a raw PS/2 pin, plus falling-edge detect on
// the synchronised level.
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   pin_i    in   raw pin level
//   sync_o   out  synchronised pin level
//   fall_o   out  one-cycle pulse when the synchronised level goes 1 -> 0
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Flops reset to 1 (idle bus level) so leaving reset never fakes a fall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// using the inhibit / request-to-send / device-clocked shift / ACK protocol.
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   cmd_data    in   byte to send, captured when cmd_valid && cmd_ready
//   cmd_valid   in   command request
//   cmd_ready   out  high only while idle
//   ps2_clk_in  in   raw PS2_CLK pin level
//   ps2_dat_in  in   raw PS2_DAT pin level
//   ps2_clk_oe  out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  out  1 = pull PS2_DAT low, 0 = release
//   busy        out  high whenever not idle (including the done/error cycle)
//   done        out  one-cycle pulse: byte sent and ACK seen
//   error       out  one-cycle pulse: timeout or missing ACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INHIBIT_PRE  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_IDX     = 4'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    clk_oe_q, clk_oe_d;
    logic                    dat_oe_q, dat_oe_d;

    logic                    clk_sync;
    logic                    clk_fall;
    logic [SYNC_STAGES-1:0]  dat_sync_q;
    logic                    dat_sync;
    logic [3:0]              idx_next;
    logic                    timeout;

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clk    (clk),
        .resetn (resetn),
        .pin_i  (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    // The data line only needs its level, so it gets a plain synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dat_sync_q <= '1;
        end else begin
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
        end
    end

    assign dat_sync = dat_sync_q[SYNC_STAGES-1];
    assign idx_next = idx_q + 4'd1;
    assign timeout  = (cnt_q == TIMEOUT_LAST);

    // The line enables are registered so reset releases the bus at once
    // and the tri-state drivers never see decode glitches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    // Timeout is checked before the fall-edge action so a stalled device
    // always ends in ERROR even if an edge lands on the limit cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd_valid) begin
                    frame_d  = {1'b1, ~^cmd_data, cmd_data};
                    cnt_d    = '0;
                    idx_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                // Start bit goes low during the last inhibit cycle.
                if (cnt_q == INHIBIT_PRE) begin
                    dat_oe_d = 1'b1;
                end
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout) begin
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_fall) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    dat_oe_d = ~frame_q[0];
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout) begin
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_fall) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        // This fall carries the device ACK (low = accepted).
                        dat_oe_d = 1'b0;
                        state_d  = dat_sync ? ERROR : WAIT_IDLE;
                    end else begin
                        idx_d    = idx_next;
                        dat_oe_d = ~frame_q[idx_next];
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d    = cnt_q + CW'(1);
                dat_oe_d = 1'b0;
                if (timeout) begin
                    state_d = ERROR;
                end else if (clk_sync && dat_sync) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx. A behavioural keyboard model clocks the
// open-drain pair and records what it samples on each rising clock edge.
// Inhibit and timeout lengths are shortened so every scenario stays short.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 60;
    localparam int TIMEOUT = 2000;
    localparam int SYNC    = 2;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmdData = 8'h00;
    logic       cmdValid = 1'b0;
    logic       cmdReady, clkOe, datOe, busy, done, error;
    logic       devClkLow = 1'b0;
    logic       devDatLow = 1'b0;
    logic       ps2Clk, ps2Dat;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;
    int doneHigh = 0;
    int errorHigh = 0;
    int bothHigh = 0;
    int doneNotBusy = 0;
    int clkOeHigh = 0;
    int releaseCycle = 0;
    int errorCycle = 0;
    int lastFallCycle = 0;
    logic prevClkOe = 1'b0;
    logic [9:0] bits;

    // Open-drain bus: either side pulling low wins.
    assign ps2Clk = ~(clkOe | devClkLow);
    assign ps2Dat = ~(datOe | devDatLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_data   (cmdData),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .ps2_clk_in (ps2Clk),
        .ps2_dat_in (ps2Dat),
        .ps2_clk_oe (clkOe),
        .ps2_dat_oe (datOe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Output monitor sampled mid-cycle: pulse widths, inhibit width and
    // the cycle numbers of clock release and error.
    always @(negedge clk) begin
        if (done) doneHigh++;
        if (error) begin
            errorHigh++;
            errorCycle = cycleCount;
        end
        if (done && error) bothHigh++;
        if (done && !busy) doneNotBusy++;
        if (clkOe) clkOeHigh++;
        if (prevClkOe && !clkOe) releaseCycle = cycleCount;
        prevClkOe = clkOe;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearStats();
        doneHigh = 0;
        errorHigh = 0;
        bothHigh = 0;
        doneNotBusy = 0;
        clkOeHigh = 0;
    endtask

    // Presents one command for a single cycle, returns mid-cycle after the accept edge.
    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        cmdData = data;
        cmdValid = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    // Waits (bounded) until a done or error pulse has been seen.
    task automatic waitEvent(input string tag, input int budget);
        int n;
        n = 0;
        while (doneHigh == 0 && errorHigh == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Keyboard model: waits for request-to-send, then produces nFalls clock
    // pulses, sampling data on each rising edge (bits 0..9). With giveAck it
    // pulls data low after the stop bit so the 11th fall carries the ACK.
    task automatic deviceFrame(input int nFalls, input bit giveAck, output logic [9:0] sampled);
        int guard;
        sampled = '0;
        guard = 0;
        while (!(ps2Clk && !ps2Dat && !clkOe) && guard < INHIBIT + 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rts_seen", (guard < INHIBIT + 100) ? 32'd1 : 32'd0, 32'd1);
        waitCycles(10);
        for (int i = 0; i < nFalls; i++) begin
            devClkLow = 1'b1;
            lastFallCycle = cycleCount;
            waitCycles(HALF);
            devClkLow = 1'b0;
            if (i < 10) sampled[i] = ps2Dat;
            if (i == 9 && giveAck) devDatLow = 1'b1;
            waitCycles(HALF);
        end
        devDatLow = 1'b0;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        waitCycles(3);
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_clk_oe", clkOe, 0);
        checkOutput("rst_dat_oe", datOe, 0);
        resetn = 1'b1;
        waitCycles(3);

        // 0xF4 with ACK
        clearStats();
        applyStimulus(CMD_ENABLE);
        checkOutput("f4_clk_oe_next", clkOe, 1);
        checkOutput("f4_cmd_ready_busy", cmdReady, 0);
        deviceFrame(11, 1'b1, bits);
        waitEvent("f4_done_seen", 200);
        waitCycles(5);
        checkOutput("f4_inhibit_len", clkOeHigh, INHIBIT);
        checkOutput("f4_data", bits[7:0], 8'hF4);
        checkOutput("f4_parity", bits[8], 0);
        checkOutput("f4_stop", bits[9], 1);
        checkOutput("f4_done_cycles", doneHigh, 1);
        checkOutput("f4_error_cycles", errorHigh, 0);
        checkOutput("f4_done_busy", doneNotBusy, 0);
        checkOutput("f4_idle_ready", cmdReady, 1);
        checkOutput("f4_idle_busy", busy, 0);

        // 0xED with an extra request mid-transfer that must be ignored
        clearStats();
        applyStimulus(CMD_SET_LEDS);
        fork
            deviceFrame(11, 1'b1, bits);
            begin
                waitCycles(500);
                checkOutput("ed_ready_mid", cmdReady, 0);
                cmdData = CMD_RESET;
                cmdValid = 1'b1;
                @(negedge clk);
                cmdValid = 1'b0;
            end
        join
        waitEvent("ed_done_seen", 200);
        waitCycles(200);
        checkOutput("ed_data", bits[7:0], 8'hED);
        checkOutput("ed_parity", bits[8], 1);
        checkOutput("ed_stop", bits[9], 1);
        checkOutput("ed_done_cycles", doneHigh, 1);
        checkOutput("ed_no_second_frame", clkOeHigh, INHIBIT);
        checkOutput("ed_idle_busy", busy, 0);

        // Device never clocks: timeout measured from clock release
        clearStats();
        applyStimulus(CMD_ENABLE);
        waitEvent("noclk_error_seen", INHIBIT + TIMEOUT + 200);
        waitCycles(3);
        checkOutput("noclk_timeout_len", errorCycle - releaseCycle, TIMEOUT);
        checkOutput("noclk_error_cycles", errorHigh, 1);
        checkOutput("noclk_done", doneHigh, 0);
        checkOutput("noclk_clk_oe", clkOe, 0);
        checkOutput("noclk_dat_oe", datOe, 0);
        checkOutput("noclk_ready", cmdReady, 1);

        // Device leaves data high on the ACK fall
        clearStats();
        applyStimulus(CMD_ENABLE);
        deviceFrame(11, 1'b0, bits);
        waitCycles(20);
        checkOutput("noack_error_cycles", errorHigh, 1);
        checkOutput("noack_done", doneHigh, 0);
        checkOutput("noack_both", bothHigh, 0);
        checkOutput("noack_ready", cmdReady, 1);

        // Device stalls after the 4th bit, then a 0xFF completes
        clearStats();
        applyStimulus(CMD_ENABLE);
        deviceFrame(4, 1'b0, bits);
        checkOutput("stall_low_nibble", bits[3:0], 4'h4);
        waitEvent("stall_error_seen", TIMEOUT + 200);
        checkOutput("stall_timeout_min", (errorCycle - lastFallCycle >= TIMEOUT) ? 32'd1 : 32'd0, 32'd1);
        checkOutput("stall_timeout_max", (errorCycle - lastFallCycle <= TIMEOUT + SYNC + 2) ? 32'd1 : 32'd0, 32'd1);
        checkOutput("stall_done", doneHigh, 0);
        waitCycles(3);
        clearStats();
        applyStimulus(CMD_RESET);
        deviceFrame(11, 1'b1, bits);
        waitEvent("ff_done_seen", 200);
        waitCycles(3);
        checkOutput("ff_data", bits[7:0], 8'hFF);
        checkOutput("ff_parity", bits[8], 1);
        checkOutput("ff_done_cycles", doneHigh, 1);
        checkOutput("ff_error_cycles", errorHigh, 0);

        // Asynchronous reset in the middle of SHIFT
        clearStats();
        applyStimulus(8'h00);
        deviceFrame(3, 1'b0, bits);
        checkOutput("arst_pre_dat_oe", datOe, 1);
        checkOutput("arst_pre_busy", busy, 1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        checkOutput("arst_clk_oe", clkOe, 0);
        checkOutput("arst_dat_oe", datOe, 0);
        @(negedge clk);
        resetn = 1'b1;
        waitCycles(2);
        checkOutput("arst_ready", cmdReady, 1);
        checkOutput("arst_busy", busy, 0);
        waitCycles(50);
        checkOutput("arst_no_error", errorHigh, 0);

        checkOutput("never_both", bothHigh, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
